// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide execution unit.
//
// Accepts one operation at a time from dispatch. A radix-2 shift-add loop
// computes multiplies and a restoring loop computes divides, one bit per
// cycle for 32 cycles. The result is held on the output port until
// writeback takes it.
//
// Handshakes: a transfer happens on any rising edge where the port's vld and
// rdy are both high. The producer must hold vld and its payload stable until
// that edge. The input side is gated off by muldiv_flush. The output side
// holds o_wdat/o_rdidx constant while o_vld is high.
//
// Build option: define MYRISCV_MUL_1CYC_EN to compute multiplies with a
// single combinational 32x32 product at accept. Divides are unaffected and
// results are identical.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   muldiv_i_vld/_rdy        operation handshake from dispatch
//   muldiv_i_op              funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU
//                                    4 DIV 5 DIVU 6 REM 7 REMU
//   muldiv_i_rs1/_rs2        operands
//   muldiv_i_rdidx           destination register index
//   muldiv_flush             abort in-flight / held operation
//   muldiv_o_vld/_rdy        result handshake to writeback
//   muldiv_o_wdat/_rdidx     result data and destination index
//   dbg_state                FSM state (0 IDLE, 1 EXEC, 2 DONE)
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            muldiv_i_vld,
  output logic            muldiv_i_rdy,
  input  logic [2:0]      muldiv_i_op,
  input  logic [XLEN-1:0] muldiv_i_rs1,
  input  logic [XLEN-1:0] muldiv_i_rs2,
  input  logic [4:0]      muldiv_i_rdidx,
  input  logic            muldiv_flush,
  output logic            muldiv_o_vld,
  input  logic            muldiv_o_rdy,
  output logic [XLEN-1:0] muldiv_o_wdat,
  output logic [4:0]      muldiv_o_rdidx,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  logic [1:0]        state;
  logic [4:0]        cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc;    // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}

  // Operand decode at accept
  logic            is_mul_i, signed_a, signed_b, a_neg, b_neg, res_neg_i;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_val;

  always_comb begin
    is_mul_i    = ~muldiv_i_op[2];
    signed_a    = is_mul_i ? (muldiv_i_op[1:0] != 2'b11) : ~muldiv_i_op[0];
    signed_b    = is_mul_i ? ~muldiv_i_op[1] : ~muldiv_i_op[0];
    a_neg       = signed_a & muldiv_i_rs1[XLEN-1];
    b_neg       = signed_b & muldiv_i_rs2[XLEN-1];
    mag_a       = a_neg ? -muldiv_i_rs1 : muldiv_i_rs1;
    mag_b       = b_neg ? -muldiv_i_rs2 : muldiv_i_rs2;
    // Remainder follows the dividend; products and quotients follow a^b.
    res_neg_i   = (is_mul_i | ~muldiv_i_op[1]) ? (a_neg ^ b_neg) : a_neg;
    div_zero    = ~is_mul_i & (muldiv_i_rs2 == '0);
    div_ovf     = ~is_mul_i & ~muldiv_i_op[0] &
                  (muldiv_i_rs1 == INT_MIN) & (muldiv_i_rs2 == ALL_ONE);
    special_val = div_zero ? (muldiv_i_op[1] ? muldiv_i_rs1 : ALL_ONE)
                           : (muldiv_i_op[1] ? '0 : INT_MIN);
  end

  // One iteration step for either algorithm
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   trial;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    trial   = {1'b0, rem_sh} - {2'b00, opnd};
    if (!op_q[2])
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    else if (trial[XLEN+1])  // borrow: restore
      acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and result selection from the raw unsigned result.
  function automatic logic [XLEN-1:0] finish_result(
    input logic [2*XLEN-1:0] raw,
    input logic [2:0]        op,
    input logic              neg
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   part;
    logic [XLEN-1:0]   res;
    prod = neg ? -raw : raw;
    part = op[1] ? raw[2*XLEN-1:XLEN] : raw[XLEN-1:0];
    if (!op[2])
      res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else
      res = neg ? -part : part;
    return res;
  endfunction

`ifdef MYRISCV_MUL_1CYC_EN
  logic [2*XLEN-1:0] prod_1c;
  assign prod_1c = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  assign muldiv_i_rdy = (state == IDLE) & ~muldiv_flush;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      muldiv_o_vld   <= 1'b0;
      muldiv_o_wdat  <= '0;
      muldiv_o_rdidx <= '0;
      cnt            <= '0;
    end else if (muldiv_flush) begin
      state        <= IDLE;
      muldiv_o_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (muldiv_i_vld) begin
            op_q           <= muldiv_i_op;
            neg_q          <= res_neg_i;
            muldiv_o_rdidx <= muldiv_i_rdidx;
            cnt            <= '0;
            if (div_zero | div_ovf) begin
              muldiv_o_wdat <= special_val;
              muldiv_o_vld  <= 1'b1;
              state         <= DONE;
            end
`ifdef MYRISCV_MUL_1CYC_EN
            else if (is_mul_i) begin
              muldiv_o_wdat <= finish_result(prod_1c, muldiv_i_op, res_neg_i);
              muldiv_o_vld  <= 1'b1;
              state         <= DONE;
            end
`endif
            else begin
              opnd  <= is_mul_i ? mag_a : mag_b;
              acc   <= {{XLEN{1'b0}}, (is_mul_i ? mag_b : mag_a)};
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            muldiv_o_wdat <= finish_result(acc_nxt, op_q, neg_q);
            muldiv_o_vld  <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (muldiv_o_rdy) begin
            muldiv_o_vld <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Testbench for muldiv_iter: directed vectors with hand-computed results,
// scoreboard queue popped by an independent output monitor.
module tb_muldiv_iter;

`ifdef MYRISCV_MUL_1CYC_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vld = 1'b0;
  logic        i_rdy;
  logic [2:0]  i_op = '0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_rdidx = '0;
  logic        flush = 1'b0;
  logic        o_vld;
  logic        o_rdy = 1'b1;
  logic [31:0] o_wdat;
  logic [4:0]  o_rdidx;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .muldiv_i_vld   (i_vld),
    .muldiv_i_rdy   (i_rdy),
    .muldiv_i_op    (i_op),
    .muldiv_i_rs1   (i_rs1),
    .muldiv_i_rs2   (i_rs2),
    .muldiv_i_rdidx (i_rdidx),
    .muldiv_flush   (flush),
    .muldiv_o_vld   (o_vld),
    .muldiv_o_rdy   (o_rdy),
    .muldiv_o_wdat  (o_wdat),
    .muldiv_o_rdidx (o_rdidx),
    .dbg_state      (dbg_state)
  );

  // scoreboard
  logic [36:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // monitor: all sampling is 1 time unit after the falling edge
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (o_vld && o_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {27'd0, o_rdidx, o_wdat}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("result", {27'd0, o_rdidx, o_wdat}, {27'd0, e});
        end
      end
    end
  end

  // driver: called at negedge+1; returns at negedge+1 of the cycle after accept
  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int waits);
    i_vld = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_rdidx = rd;
    waits = 0;
    while (!i_rdy && waits < 100) begin
      @(negedge clk); #1;
      waits++;
    end
    if (waits >= 100) check("accept_timeout", 64'(waits), 64'd0);
    @(posedge clk);
    @(negedge clk);
    i_vld = 1'b0;
    #1;
  endtask

  // issue with expected result; checks accept-to-o_vld latency
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                       output int waits);
    int lat;
    exp_q.push_back({rd, exp});
    start(op, a, b, rd, waits);
    lat = 1;
    while (!o_vld && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int waits;
    logic seen;

    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_o_vld", 64'(o_vld), 64'd0);
    check("rst_o_wdat", 64'(o_wdat), 64'd0);
    check("rst_o_rdidx", 64'(o_rdidx), 64'd0);
    check("rst_i_rdy", 64'(i_rdy), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);

    // directed vectors
    add_vec(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    add_vec(OP_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT);
    add_vec(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    add_vec(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
    add_vec(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
    add_vec(OP_MULHU,  32'h8000_0000,  32'd2,         32'd1,         MUL_LAT);
    add_vec(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
    add_vec(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
    add_vec(OP_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT);
    add_vec(OP_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT);
    add_vec(OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    add_vec(OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_LAT);
    add_vec(OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, DIV_LAT);
    add_vec(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    add_vec(OP_REMU,   32'd5,          32'd0,         32'd5,         1);
    add_vec(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_vec(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    foreach (vecs[i])
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat, waits);

    // backpressure: hold result for 10 cycles
    @(negedge clk); #1;
    o_rdy = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, DIV_LAT, waits);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check("bp_o_vld", 64'(o_vld), 64'd1);
      check("bp_wdat", 64'(o_wdat), 64'd14);
      check("bp_rdidx", 64'(o_rdidx), 64'd9);
      check("bp_i_rdy", 64'(i_rdy), 64'd0);
    end
    @(negedge clk);
    o_rdy = 1'b1;
    #1;
    @(negedge clk); #1;
    check("hs_i_rdy", 64'(i_rdy), 64'd1);
    check("hs_o_vld", 64'(o_vld), 64'd0);
    issue(OP_MULHU, 32'h8000_0000, 32'd2, 5'd10, 32'd1, MUL_LAT, waits);
    check("hs_accept_waits", 64'(waits), 64'd0);

    // flush at EXEC counter 15
    @(negedge clk); #1;
    start(OP_DIVU, 32'd1000, 32'd3, 5'd11, waits);
    repeat (15) @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_exec_state", 64'(dbg_state), 64'd1);
    check("fl_exec_i_rdy", 64'(i_rdy), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_exec_idle", 64'(dbg_state), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (o_vld) seen = 1'b1;
    end
    check("fl_exec_no_vld", 64'(seen), 64'd0);

    // flush while holding a result in DONE
    o_rdy = 1'b0;
    start(OP_DIVU, 32'd100, 32'd7, 5'd12, waits);
    waits = 0;
    while (!o_vld && waits < 100) begin
      @(negedge clk); #1;
      waits++;
    end
    check("fl_done_reached", 64'(o_vld), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_done_o_vld", 64'(o_vld), 64'd0);
    check("fl_done_idle", 64'(dbg_state), 64'd0);
    o_rdy = 1'b1;

    // flush together with i_vld: nothing accepted
    @(negedge clk); #1;
    flush = 1'b1;
    i_vld = 1'b1; i_op = OP_DIV; i_rs1 = 32'd5; i_rs2 = 32'd0; i_rdidx = 5'd13;
    #1;
    check("fl_vld_i_rdy", 64'(i_rdy), 64'd0);
    @(negedge clk);
    i_vld = 1'b0;
    flush = 1'b0;
    #1;
    check("fl_vld_idle", 64'(dbg_state), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (o_vld) seen = 1'b1;
    end
    check("fl_vld_no_vld", 64'(seen), 64'd0);

    // reset mid-operation clears output registers
    start(OP_DIVU, 32'd100, 32'd7, 5'd21, waits);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_state", 64'(dbg_state), 64'd0);
    check("rst_mid_o_vld", 64'(o_vld), 64'd0);
    check("rst_mid_wdat", 64'(o_wdat), 64'd0);
    check("rst_mid_rdidx", 64'(o_rdidx), 64'd0);

    repeat (5) @(negedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
